mc_control_fsm: RTL and testbench

Multicycle control unit for the ARM-subset processor. It sequences the shared single-memory datapath through the FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK steps, one Moore state per cycle. It decodes the instruction and evaluates the condition field against its own NZCV flag registers. It drives every mux select and write strobe of the datapath, which holds the instruction in its IR.

---
 rtl/mc_ctrl_pkg.sv | 81 ++++++++
 rtl/mc_cond_unit.sv | 34 +++
 rtl/mc_control_fsm.sv | 170 +++++++++++++++++
 tb/tb_mc_control_fsm.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg -- shared encodings for the multicycle control unit.
//   - mc_state_e : FSM state enum (one Moore state per datapath step)
//   - mux select / ALU control encodings driven onto the datapath
//   - data-processing cmd codes, Op field codes, condition codes
//   - cond_holds(): ARM condition evaluation against NZCV
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
    S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
  } mc_state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] SRCA_RD1  = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // nzcv is {N, Z, C, V}; 1111 is treated as "never".
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: cond_holds = z;
      COND_NE: cond_holds = !z;
      COND_CS: cond_holds = c;
      COND_CC: cond_holds = !c;
      COND_MI: cond_holds = n;
      COND_PL: cond_holds = !n;
      COND_VS: cond_holds = v;
      COND_VC: cond_holds = !v;
      COND_HI: cond_holds = c && !z;
      COND_LS: cond_holds = !c || z;
      COND_GE: cond_holds = (n == v);
      COND_LT: cond_holds = (n != v);
      COND_GT: cond_holds = !z && (n == v);
      COND_LE: cond_holds = z || (n != v);
      COND_AL: cond_holds = 1'b1;
      default: cond_holds = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_cond_unit.sv
// mc_cond_unit -- NZCV flag registers and condition check.
//   clk, reset  : clock, asynchronous active-high reset (flags -> 0000)
//   cond        : instruction condition field (IR[31:28])
//   alu_flags   : NZCV produced by the ALU this cycle
//   flag_w      : [1] write N,Z  [0] write C,V (already qualified by state)
//   cond_ex     : condition passes against the stored (pre-update) flags
module mc_cond_unit
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  output logic       cond_ex
);

  logic [3:0] flags_q, flags_d;

  assign cond_ex = cond_holds(cond, flags_q);

  // A flag group only updates if the instruction's own condition passes.
  always_comb begin
    flags_d = flags_q;
    if (flag_w[1] && cond_ex) flags_d[3:2] = alu_flags[3:2];
    if (flag_w[0] && cond_ex) flags_d[1:0] = alu_flags[1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) flags_q <= 4'b0000;
    else       flags_q <= flags_d;
  end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm -- multicycle control unit for the ARM-subset datapath.
//   clk, reset  : clock, asynchronous active-high reset (state -> FETCH)
//   Instr       : IR bits [31:12] (Instr[i] is IR bit i+12)
//   ALUFlags    : NZCV from the ALU this cycle
//   PCWrite, IRWrite, RegWrite, MemWrite : write strobes, forced 0 in reset
//   AdrSrc, RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl : selects
//   ByteLoad    : byte-load select; live only when MC_LDRB_EN is defined,
//                 otherwise tied 0 and LDRB behaves as LDR.
// Outputs are Moore: decoded combinationally from the state and Instr.
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUControl,
  output logic        ByteLoad
);

  mc_state_e state_q, state_d;

  logic [3:0] cond, cmd;
  logic [1:0] op;
  logic       imm_bit, sl_bit;
  logic       unused_ir_low;

  assign cond    = Instr[19:16];
  assign op      = Instr[15:14];
  assign imm_bit = Instr[13];
  assign cmd     = Instr[12:9];
  assign sl_bit  = Instr[8];            // S for data-processing, L for memory
  assign unused_ir_low = ^Instr[7:0];

  logic       is_exec, cond_ex;
  logic       next_pc, branch, reg_w, mem_w, ir_w;
  logic       no_write, is_mov, flag_w_nz;
  logic [1:0] alu_dp, flag_w;

  assign is_exec = (state_q == S_EXECR) || (state_q == S_EXECI);

  // Data-processing decode; only used in EXEC/ALUWB.
  always_comb begin
    alu_dp   = ALU_ADD;
    no_write = 1'b0;
    is_mov   = 1'b0;
    case (cmd)
      CMD_ADD: alu_dp = ALU_ADD;
      CMD_SUB: alu_dp = ALU_SUB;
      CMD_AND: alu_dp = ALU_AND;
      CMD_ORR: alu_dp = ALU_ORR;
      CMD_CMP: begin alu_dp = ALU_SUB; no_write = 1'b1; end
      CMD_MOV: is_mov = 1'b1;
      default: no_write = 1'b1;
    endcase
  end

  assign flag_w_nz = sl_bit || (cmd == CMD_CMP);
  assign flag_w = is_exec
    ? {flag_w_nz, flag_w_nz && (cmd == CMD_ADD || cmd == CMD_SUB || cmd == CMD_CMP)}
    : 2'b00;

  mc_cond_unit u_cond (
    .clk       (clk),
    .reset     (reset),
    .cond      (cond),
    .alu_flags (ALUFlags),
    .flag_w    (flag_w),
    .cond_ex   (cond_ex)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_MEM:  state_d = S_MEMADR;
          OP_BR:   state_d = S_BRANCH;
          OP_DP:   state_d = imm_bit ? S_EXECI : S_EXECR;
          default: state_d = S_FETCH;   // undefined Op: drop it
        endcase
      end
      S_MEMADR: state_d = sl_bit ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR,
      S_EXECI:  state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    next_pc    = 1'b0;
    branch     = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    ir_w       = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = SRCA_RD1;
    ALUSrcB    = SRCB_RD2;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ir_w      = 1'b1;
        next_pc   = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin           // PC+4 again -> PC+8 for R15 reads
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_MEMADR: ALUSrcB = imm_bit ? SRCB_RD2 : SRCB_IMM;
      S_MEMRD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_w     = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB    = (state_q == S_EXECI) ? SRCB_IMM : SRCB_RD2;
        ALUSrcA    = is_mov ? SRCA_ZERO : SRCA_RD1;
        ALUControl = alu_dp;
      end
      S_ALUWB: reg_w = !no_write;
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  assign ImmSrc = (op == 2'b11) ? 2'b00 : op;
  assign RegSrc = {(op == OP_MEM) && !sl_bit, op == OP_BR};

  assign PCWrite  = !reset && (next_pc || (branch && cond_ex));
  assign IRWrite  = !reset && ir_w;
  assign RegWrite = !reset && reg_w && cond_ex;
  assign MemWrite = !reset && mem_w && cond_ex;

`ifdef MC_LDRB_EN
  assign ByteLoad = ((state_q == S_MEMRD) || (state_q == S_MEMWB)) && (op == OP_MEM) && Instr[10];
`else
  assign ByteLoad = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;
  import mc_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ByteLoad;
  logic [1:0] RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl;

  mc_control_fsm u_dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl), .ByteLoad(ByteLoad)
  );

  // Output bundle layout:
  // {pcw, irw, rw, mw, adr, regsrc[2], immsrc[2], srca[2], srcb[2], res[2], aluc[2], bl}
  logic [17:0] obs;
  assign obs = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, RegSrc, ImmSrc,
                ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ByteLoad};

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q[$];
  logic [17:0] mask_q[$];
  mc_state_e   st_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_vec(input string tag, input logic [17:0] o, input logic [17:0] e,
                           input logic [17:0] m);
    n_checks++;
    assert ((o & m) === (e & m)) else begin
      n_errors++;
      $error("FAIL %s: observed %h required %h (mask %h)", tag, o & m, e & m, m);
    end
  endtask

  task automatic check_4(input string tag, input logic [3:0] o, input logic [3:0] e);
    n_checks++;
    assert (o === e) else begin
      n_errors++;
      $error("FAIL %s: observed %b required %b", tag, o, e);
    end
  endtask

  // Expected outputs for one state of instruction ins; ce = condition outcome
  // in that state, rst = reset currently asserted. Unconstrained fields are masked.
  task automatic push_exp(input mc_state_e st, input logic [19:0] ins, input logic ce,
                          input logic rst);
    logic [1:0] op, srca, srcb, res, aluc, regsrc;
    logic [3:0] cmd;
    logic i_b, sl, pcw, irw, rw, mw, adr, bl;
    logic m_adr, m_srca, m_srcb, m_res, m_regsrc, m_immsrc;
    op = ins[15:14]; i_b = ins[13]; cmd = ins[12:9]; sl = ins[8];
    pcw = 0; irw = 0; rw = 0; mw = 0; adr = 0; bl = 0;
    srca = 0; srcb = 0; res = 0; aluc = 2'b00;
    m_adr = 0; m_srca = 0; m_srcb = 0; m_res = 0;
    m_regsrc = (st != S_FETCH);
    m_immsrc = (st != S_FETCH) && (op != 2'b11);
    regsrc = {op == 2'b01 && !sl, op == 2'b10};
    case (st)
      S_FETCH:  begin irw = 1; pcw = 1; m_adr = 1; adr = 0; m_srca = 1; srca = 2'b01;
                      m_srcb = 1; srcb = 2'b10; m_res = 1; res = 2'b10; end
      S_DECODE: begin m_srca = 1; srca = 2'b01; m_srcb = 1; srcb = 2'b10;
                      m_res = 1; res = 2'b10; end
      S_MEMADR: begin m_srca = 1; srca = 2'b00; m_srcb = 1; srcb = i_b ? 2'b00 : 2'b01; end
      S_MEMRD:  begin m_adr = 1; adr = 1; end
      S_MEMWB:  begin m_res = 1; res = 2'b01; rw = ce; end
      S_MEMWR:  begin m_adr = 1; adr = 1; mw = ce; end
      S_EXECR, S_EXECI: begin
        m_srcb = 1; srcb = (st == S_EXECI) ? 2'b01 : 2'b00;
        m_srca = 1; srca = (cmd == 4'b1101) ? 2'b10 : 2'b00;
        case (cmd)
          4'b0010, 4'b1010: aluc = 2'b01;
          4'b0000:          aluc = 2'b10;
          4'b1100:          aluc = 2'b11;
          default:          aluc = 2'b00;
        endcase
      end
      S_ALUWB: begin
        m_res = 1; res = 2'b00;
        rw = ce && (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b0000 ||
                    cmd == 4'b1100 || cmd == 4'b1101);
      end
      S_BRANCH: begin m_srca = 1; srca = 2'b00; m_srcb = 1; srcb = 2'b01;
                      m_res = 1; res = 2'b10; pcw = ce; end
      default: ;
    endcase
`ifdef MC_LDRB_EN
    bl = (st == S_MEMRD || st == S_MEMWB) && op == 2'b01 && ins[10];
`endif
    if (rst) begin pcw = 0; irw = 0; rw = 0; mw = 0; end
    exp_q.push_back({pcw, irw, rw, mw, adr, regsrc, (op == 2'b11) ? 2'b00 : op,
                     srca, srcb, res, aluc, bl});
    mask_q.push_back({4'b1111, m_adr, {2{m_regsrc}}, {2{m_immsrc}}, {2{m_srca}},
                      {2{m_srcb}}, {2{m_res}}, 2'b11, 1'b1});
    st_q.push_back(st);
  endtask

  task automatic compare_one(input string tag);
    logic [17:0] e, m;
    mc_state_e s;
    e = exp_q.pop_front(); m = mask_q.pop_front(); s = st_q.pop_front();
    check_4({tag, "_state"}, u_dut.state_q, s);
    check_vec({tag, "_outs"}, obs, e, m);
  endtask

  // ---------------- driver ----------------
  // Entered just after a rising edge with the DUT in FETCH; drives the IR and
  // compares one queued entry per cycle on the falling edge.
  task automatic run(input logic [19:0] ins, input string name);
    int k;
    Instr = ins;
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      compare_one($sformatf("%s_c%0d", name, k));
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic push_seq4(input logic [19:0] ins, input mc_state_e s2, input mc_state_e s3,
                           input logic ce_last);
    push_exp(S_FETCH, ins, 1'b1, 1'b0);
    push_exp(S_DECODE, ins, 1'b1, 1'b0);
    push_exp(s2, ins, 1'b1, 1'b0);
    push_exp(s3, ins, ce_last, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [19:0] ins;
    logic [3:0]  rc;
    logic        ri;
    reset = 1'b1; Instr = 20'h0; ALUFlags = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    push_exp(S_FETCH, 20'h0, 1'b1, 1'b1);
    @(negedge clk);
    compare_one("reset");
    check_4("reset_flags", u_dut.u_cond.flags_q, 4'b0000);
    @(posedge clk); #1;
    reset = 1'b0;

    // MOV r0,#0
    push_seq4(20'he3a00, S_EXECI, S_ALUWB, 1'b1);
    run(20'he3a00, "mov");

    // LDR r3
    push_exp(S_FETCH, 20'he59f3, 1, 0); push_exp(S_DECODE, 20'he59f3, 1, 0);
    push_exp(S_MEMADR, 20'he59f3, 1, 0); push_exp(S_MEMRD, 20'he59f3, 1, 0);
    push_exp(S_MEMWB, 20'he59f3, 1, 0);
    run(20'he59f3, "ldr");

    // LDRB r5,[r4,r0]
    push_exp(S_FETCH, 20'he7d45, 1, 0); push_exp(S_DECODE, 20'he7d45, 1, 0);
    push_exp(S_MEMADR, 20'he7d45, 1, 0); push_exp(S_MEMRD, 20'he7d45, 1, 0);
    push_exp(S_MEMWB, 20'he7d45, 1, 0);
    run(20'he7d45, "ldrb");

    // STR
    push_seq4(20'he5801, S_MEMADR, S_MEMWR, 1'b1);
    run(20'he5801, "str");

    // Undefined Op
    push_exp(S_FETCH, 20'hec000, 1, 0); push_exp(S_DECODE, 20'hec000, 1, 0);
    run(20'hec000, "undef");

    // CMP r5,#0 with Z result, then BEQ taken
    ALUFlags = 4'b0100;
    push_seq4(20'he3550, S_EXECI, S_ALUWB, 1'b1);
    run(20'he3550, "cmp_z");
    check_4("cmp_z_flags", u_dut.u_cond.flags_q, 4'b0100);
    ALUFlags = 4'b0000;
    push_exp(S_FETCH, 20'h0a000, 1, 0); push_exp(S_DECODE, 20'h0a000, 1, 0);
    push_exp(S_BRANCH, 20'h0a000, 1, 0);
    run(20'h0a000, "beq_taken");

    // CMP with nonzero result, then BEQ not taken
    push_seq4(20'he3550, S_EXECI, S_ALUWB, 1'b1);
    run(20'he3550, "cmp_nz");
    push_exp(S_FETCH, 20'h0a000, 1, 0); push_exp(S_DECODE, 20'h0a000, 1, 0);
    push_exp(S_BRANCH, 20'h0a000, 0, 0);
    run(20'h0a000, "beq_not");

    // ADDSNE: passes in EXEC on Z=0, sets Z, so fails in ALUWB (no RegWrite)
    ALUFlags = 4'b0100;
    push_seq4(20'h12910, S_EXECI, S_ALUWB, 1'b0);
    run(20'h12910, "addsne");
    check_4("addsne_flags", u_dut.u_cond.flags_q, 4'b0100);
    ALUFlags = 4'b0000;

    // Reset asserted in MEMRD of an LDR
    push_exp(S_FETCH, 20'he59f3, 1, 0); push_exp(S_DECODE, 20'he59f3, 1, 0);
    push_exp(S_MEMADR, 20'he59f3, 1, 0);
    run(20'he59f3, "ldr_abort");
    push_exp(S_MEMRD, 20'he59f3, 1, 0);
    compare_one("ldr_abort_memrd");
    reset = 1'b1;
    #1;
    push_exp(S_FETCH, 20'he59f3, 1, 1);
    compare_one("rst_async");
    @(posedge clk); #1;
    push_exp(S_FETCH, 20'he59f3, 1, 1);
    compare_one("rst_held");
    check_4("rst_flags", u_dut.u_cond.flags_q, 4'b0000);
    reset = 1'b0;
    // Flags cleared, so BEQ must not be taken
    push_exp(S_FETCH, 20'h0a000, 1, 0); push_exp(S_DECODE, 20'h0a000, 1, 0);
    push_exp(S_BRANCH, 20'h0a000, 0, 0);
    run(20'h0a000, "beq_after_rst");

    // Random AL data-processing ops (ADD/SUB/AND/ORR, reg or imm)
    for (int n = 0; n < 6; n++) begin
      case ($urandom_range(0, 3))
        0: rc = 4'b0100;
        1: rc = 4'b0010;
        2: rc = 4'b0000;
        default: rc = 4'b1100;
      endcase
      ri = 1'($urandom_range(0, 1));
      ins = {4'he, 2'b00, ri, rc, 1'b0, 8'($urandom_range(0, 255))};
      push_seq4(ins, ri ? S_EXECI : S_EXECR, S_ALUWB, 1'b1);
      run(ins, $sformatf("dp%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed no completion, required completion before 100000");
    $fatal(1, "timeout");
  end

endmodule
